// File: rtl/iomem_rx_fifo.sv
// iomem_rx_fifo: receive byte packer and word FIFO drained over the iomem bus.
//
// Bytes from the network datapath are packed little-endian into 32-bit words.
// Each word is stored with its byte count and end-of-packet flag. The CPU
// reads the words through a register window selected by iomem_addr[31:24].
//
// Register window, selected by iomem_addr[3:2]:
//   0x00 DATA   (RO) returns the head word and pops it; returns 0 when empty
//   0x04 STATUS (RO) [0] nonempty [1] full [2] overflow [4:3] head bytes-1
//                    [5] head last [15:8] entry count
//   0x08 CTRL   (RW) [0] enable [1] irq_en [2] flush (write-1, reads 0)
//   0x0C        reads 0, writes ignored
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   iomem_valid/ready       bus handshake; ready is a one-cycle pulse
//   iomem_wstrb/addr/wdata  bus request; wstrb==0 means read
//   iomem_rdata             read data, valid while iomem_ready is high
//   rx_valid/ready          byte stream handshake (rx_ready is combinational)
//   rx_data/rx_last         byte and end-of-packet marker
//   irq                     registered level interrupt (irq_en & nonempty)
//
// Build option RXFIFO_DROP_EN: rx_ready follows enable alone. A word that
// completes while the FIFO is full is dropped and sets the sticky overflow
// bit. Without it the stream is backpressured and overflow stays 0.

module iomem_rx_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter logic [7:0]  ADDR_HI = 8'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 35;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          enable;
    logic          irq_en;
    logic          overflow;
    logic [1:0]    idx;
    logic [23:0]   hold;

    logic          full;
    logic          empty;
    logic          decode;
    logic          is_rd;
    logic [1:0]    reg_sel;
    logic          pop;
    logic          ctrl_wr;
    logic          flush;
    logic          accept;
    logic          push_req;
    logic          push;
    logic          drop;
    logic [31:0]   word;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic [31:0]   status;
    logic [31:0]   rd_val;
    logic          unused_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Bus decode: one request per handshake, none during the ready cycle
    assign decode  = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
    assign is_rd   = (iomem_wstrb == 4'b0000);
    assign reg_sel = iomem_addr[3:2];
    assign pop     = decode && is_rd && (reg_sel == 2'd0) && !empty;
    assign ctrl_wr = decode && iomem_wstrb[0] && (reg_sel == 2'd2);
    assign flush   = ctrl_wr && iomem_wdata[2];

    assign accept   = rx_valid && rx_ready;
    assign push_req = accept && ((idx == 2'd3) || rx_last);

`ifdef RXFIFO_DROP_EN
    assign rx_ready = enable;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
`else
    assign rx_ready = enable && !full;
    assign push     = push_req;
    assign drop     = 1'b0;
`endif

    // Current byte merged into its lane; lanes above idx are still zero in hold
    always_comb begin
        word = {8'h00, hold};
        case (idx)
            2'd0: word[7:0]   = rx_data;
            2'd1: word[15:8]  = rx_data;
            2'd2: word[23:16] = rx_data;
            2'd3: word[31:24] = rx_data;
        endcase
    end

    assign entry = {word, idx, rx_last};

    // Head fields are reported as 0 while the FIFO is empty
    assign status = {16'h0000, 8'(count), 2'b00,
                     head[0] && !empty, head[2:1] & {2{!empty}},
                     overflow, full, !empty};

    always_comb begin
        rd_val = 32'h0;
        case (reg_sel)
            2'd0: rd_val = empty ? 32'h0 : head[34:3];
            2'd1: rd_val = status;
            2'd2: rd_val = {30'h0, irq_en, enable};
            2'd3: rd_val = 32'h0;
        endcase
    end

    // Storage array, no reset needed; pointers define validity
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= entry;
        end
    end

    // Bus response, control register and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            irq         <= 1'b0;
        end else begin
            iomem_ready <= decode;
            iomem_rdata <= decode ? rd_val : 32'h0;
            irq         <= irq_en && !empty;
            if (ctrl_wr) begin
                enable <= iomem_wdata[0];
                irq_en <= iomem_wdata[1];
            end
        end
    end

    // Packer, FIFO pointers and overflow; flush beats push and pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            idx      <= 2'd0;
            hold     <= 24'h0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                if (push_req) begin
                    idx  <= 2'd0;
                    hold <= 24'h0;
                end else begin
                    idx <= idx + 2'd1;
                    case (idx)
                        2'd0:    hold[7:0]   <= rx_data;
                        2'd1:    hold[15:8]  <= rx_data;
                        2'd2:    hold[23:16] <= rx_data;
                        default: ;
                    endcase
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign unused_ok = ^{iomem_addr[23:4], iomem_addr[1:0],
                         iomem_wstrb[3:1], iomem_wdata[31:3]};

endmodule

// File: tb/tb_iomem_rx_fifo.sv
// Scoreboard bench for iomem_rx_fifo: bus reads push their expected data,
// a negedge monitor compares iomem_rdata whenever iomem_ready is seen.
module tb_iomem_rx_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_last = 1'b0;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    localparam logic [31:0] BASE = 32'h0400_0000;
    localparam logic [3:0]  A_DATA = 4'h0, A_STAT = 4'h4, A_CTRL = 4'h8, A_RSV = 4'hC;

    iomem_rx_fifo dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_last(rx_last), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Monitor: every completion pops one scoreboard entry
    always @(negedge clk) begin
        if (iomem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_ready");
            end else begin
                logic [31:0] e;
                bit          c;
                string       n;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                n = name_q.pop_front();
                if (c) check(n, iomem_rdata, e);
            end
        end
    end

    // Called at a negedge; returns at the negedge where ready is seen
    task automatic bus_xfer(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] wd,
                            input bit chk, input logic [31:0] exp, input string nm);
        bit seen;
        exp_q.push_back(exp);
        chk_q.push_back(chk);
        name_q.push_back(nm);
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'(off);
        iomem_wstrb = strb;
        iomem_wdata = wd;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (iomem_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (!seen) begin
            void'(exp_q.pop_back());
            void'(chk_q.pop_back());
            void'(name_q.pop_back());
            fail_now({nm, "_timeout"});
        end
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string nm);
        bus_xfer(off, 4'h0, 32'h0, 1'b1, exp, nm);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        bus_xfer(off, 4'hF, data, 1'b0, 32'h0, "write");
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = l;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        else fail_now("rx_accept");
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(iomem_ready), 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        rd(A_CTRL, 32'h0, "rst_ctrl");
        rd(A_STAT, 32'h0, "rst_status");

        // Basic packing: full word then single-byte tail
        wr(A_CTRL, 32'h1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b1);
        rd(A_STAT, 32'h0000_0219, "pk_status1");
        rd(A_DATA, 32'h4433_2211, "pk_data1");
        rd(A_STAT, 32'h0000_0121, "pk_status2");
        rd(A_DATA, 32'h0000_0055, "pk_data2");
        rd(A_STAT, 32'h0, "pk_status_end");

        // Empty read returns 0, ready is one cycle
        rd(A_DATA, 32'h0, "empty_data");
        @(negedge clk);
        check("ready_pulse", 32'(iomem_ready), 32'h0);
        rd(A_STAT, 32'h0, "empty_status");

        // Reserved and read-only registers ignore writes
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_RSV, 32'h0, "rsv_read");
        wr(A_STAT, 32'hFFFF_FFFF);
        wr(A_DATA, 32'hFFFF_FFFF);
        rd(A_STAT, 32'h0, "ro_write_status");

        // Disable mid-word keeps partial data
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        wr(A_CTRL, 32'h0);
        check("disabled_rx_ready", 32'(rx_ready), 32'h0);
        wr(A_CTRL, 32'h1);
        send_byte(8'h30, 1'b1);
        rd(A_STAT, 32'h0000_0131, "retain_status");
        rd(A_DATA, 32'h0030_2010, "retain_data");

        // Flush discards the partial word, keeps enable
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        wr(A_CTRL, 32'h5);
        rd(A_CTRL, 32'h1, "flush_ctrl");
        send_byte(8'h33, 1'b1);
        rd(A_DATA, 32'h0000_0033, "flush_data");

        // Fill with 4*DEPTH bytes and no reads
        for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
`ifdef RXFIFO_DROP_EN
        check("full_rx_ready_drop", 32'(rx_ready), 32'h1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hE2, 1'b0);
        send_byte(8'hE3, 1'b0);
        rd(A_STAT, 32'h0000_101F, "drop_status");
        rd(A_DATA, 32'h0302_0100, "drop_head");
        rd(A_STAT, 32'h0000_0F1D, "drop_status2");
        wr(A_CTRL, 32'h5);
        rd(A_STAT, 32'h0, "drop_flush_status");
        rd(A_CTRL, 32'h1, "drop_flush_ctrl");
`else
        check("full_rx_ready", 32'(rx_ready), 32'h0);
        rd(A_STAT, 32'h0000_101B, "full_status");
        rd(A_DATA, 32'h0302_0100, "full_pop");
        check("after_pop_rx_ready", 32'(rx_ready), 32'h1);
        send_byte(8'hA0, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        check("refull_rx_ready", 32'(rx_ready), 32'h0);
        rd(A_STAT, 32'h0000_101B, "refull_status");
        for (int k = 1; k < 16; k++) begin
            rd(A_DATA, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, "drain");
        end
        rd(A_DATA, 32'hA3A2_A1A0, "drain_last");
        rd(A_STAT, 32'h0, "drain_status");
`endif

        // Interrupt latency on push and pop
        wr(A_CTRL, 32'h3);
        check("irq_idle", 32'(irq), 32'h0);
        send_byte(8'h77, 1'b1);
        check("irq_push_plus1", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_push_plus2", 32'(irq), 32'h1);
        rd(A_DATA, 32'h0000_0077, "irq_data");
        check("irq_pop_plus1", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_pop_plus2", 32'(irq), 32'h0);

        // Reset mid-packet discards partial data and CTRL
        wr(A_CTRL, 32'h1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(A_CTRL, 32'h0, "rst2_ctrl");
        check("rst2_rx_ready", 32'(rx_ready), 32'h0);
        wr(A_CTRL, 32'h1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        rd(A_DATA, 32'hDDCC_BBAA, "rst2_data");
        rd(A_STAT, 32'h0, "rst2_status");

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) fail_now("scoreboard_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
